// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package prefetch_pkg;

    // One buffered instruction word together with its bus error flag.
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } fetch_entry_t;

    localparam int unsigned PF_DEFAULT_DEPTH           = 4;
    localparam int unsigned PF_DEFAULT_MAX_OUTSTANDING = 2;

    // Fetch addresses are always word aligned.
    localparam logic [31:0] PF_WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] pf_align(input logic [31:0] addr);
        return addr & PF_WORD_MASK;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Instruction word FIFO: power-of-two depth, single-cycle flush, occupancy count.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = PF_DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         wr_en_i,
    input  fetch_entry_t                 wr_data_i,
    input  logic                         rd_en_i,
    output fetch_entry_t                 rd_data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next-state: flush wins; otherwise write at tail, read at head.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en_i) begin
                mem_d[wptr_q] = wr_data_i;
                wptr_d        = wptr_q + 1'b1;
            end
            if (rd_en_i) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({wr_en_i, rd_en_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // State registers; reset empties the FIFO and clears stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign rd_data_o = mem_q[rptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues word fetches on a req/gnt/rvalid bus,
// buffers responses in order, and handles branch redirects by flushing and
// discarding in-flight responses. Hardware-loop redirect (hwlp_jump_i) is
// only present when PREFETCH_HWLP_EN is defined.
module prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int unsigned DEPTH           = PF_DEFAULT_DEPTH,
    parameter int unsigned MAX_OUTSTANDING = PF_DEFAULT_MAX_OUTSTANDING
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_rvalid_i,
    input  logic        instr_err_i,
    output logic        busy_o,
    input  logic        hwlp_jump_i,
    input  logic [31:0] hwlp_target_i
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    // Outstanding/discard counts can reach MAX_OUTSTANDING+1 <= DEPTH+1.
    localparam int unsigned OW = $clog2(DEPTH+2);

    logic [31:0]   addr_q, addr_d;
    logic [31:0]   pend_addr_q, pend_addr_d;
    logic          pend_q, pend_d;
    logic          held_q, held_d;
    logic          booted_q, booted_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] discard_q, discard_d;

    logic          redirect;
    logic [31:0]   redirect_addr;
    logic          new_req;
    logic          gnt_fire;
    logic          drop;
    logic          wr_en;
    logic          consume;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  head;
    fetch_entry_t  wr_entry;

`ifdef PREFETCH_HWLP_EN
    // Hardware-loop jump redirects after the current handshake; branch wins.
    assign redirect      = branch_i | hwlp_jump_i;
    assign redirect_addr = pf_align(branch_i ? branch_addr_i : hwlp_target_i);
`else
    assign redirect      = branch_i;
    assign redirect_addr = pf_align(branch_addr_i);
    logic unused_hwlp;
    assign unused_hwlp   = ^{hwlp_jump_i, hwlp_target_i};
`endif

    // A fresh request needs a boot address, bus credit and guaranteed FIFO room;
    // it is never raised in a redirect cycle. A held request stays up until granted.
    assign new_req = req_i & booted_q & ~redirect
                   & (32'(outst_q) < MAX_OUTSTANDING)
                   & ((32'(fifo_count) + 32'(outst_q)) < DEPTH);
    assign instr_req_o  = held_q | new_req;
    assign instr_addr_o = addr_q;
    assign gnt_fire     = instr_req_o & instr_gnt_i;

    // Responses from before a redirect (or during it) never reach the FIFO.
    assign drop     = redirect | (discard_q != '0);
    assign wr_en    = instr_rvalid_i & ~drop;
    assign wr_entry = '{data: instr_rdata_i, err: instr_err_i};

    assign fetch_valid_o = ~fifo_empty & ~branch_i;
    assign consume       = fetch_valid_o & fetch_ready_i;
    assign fetch_rdata_o = head.data;
    assign fetch_err_o   = head.err & ~fifo_empty;
    assign busy_o        = instr_req_o | (outst_q != '0);

    // Next-state for address, held request, credits and discard bookkeeping.
    always_comb begin
        addr_d      = addr_q;
        pend_addr_d = pend_addr_q;
        pend_d      = pend_q;
        booted_d    = booted_q;
        discard_d   = discard_q;
        held_d      = instr_req_o & ~instr_gnt_i;
        outst_d     = outst_q;

        case ({gnt_fire, instr_rvalid_i})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: ;
        endcase

        if (redirect) begin
            booted_d  = 1'b1;
            // Everything in flight is stale, including a held request that
            // will be (or is now being) granted; a response this cycle is dropped.
            discard_d = outst_q + OW'(held_q) - OW'(instr_rvalid_i);
            if (held_q && !instr_gnt_i) begin
                // Held address must stay stable; park the target until the grant.
                pend_d      = 1'b1;
                pend_addr_d = redirect_addr;
            end else begin
                pend_d = 1'b0;
                addr_d = redirect_addr;
            end
        end else begin
            if (instr_rvalid_i && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (gnt_fire) begin
                if (pend_q) begin
                    addr_d = pend_addr_q;
                    pend_d = 1'b0;
                end else begin
                    addr_d = addr_q + 32'd4;
                end
            end
        end
    end

    // Control registers; reset abandons all in-flight transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            pend_addr_q <= '0;
            pend_q      <= 1'b0;
            held_q      <= 1'b0;
            booted_q    <= 1'b0;
            outst_q     <= '0;
            discard_q   <= '0;
        end else begin
            addr_q      <= addr_d;
            pend_addr_q <= pend_addr_d;
            pend_q      <= pend_d;
            held_q      <= held_d;
            booted_q    <= booted_d;
            outst_q     <= outst_d;
            discard_q   <= discard_d;
        end
    end

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (redirect),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_entry),
        .rd_en_i   (consume),
        .rd_data_o (head),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed vector table, hand-written corner
// sequences and a randomized run against a stream-level reference model.
module tb_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk, rst_n, req_i, branch_i, fetch_ready_i;
    logic [31:0] branch_addr_i;
    logic        fetch_valid_o, fetch_err_o;
    logic [31:0] fetch_rdata_o;
    logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i, busy_o;
    logic [31:0] instr_addr_o, instr_rdata_i;
    logic        hwlp_jump_i;
    logic [31:0] hwlp_target_i;

    int checks = 0;
    int errors = 0;

    prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i),
        .branch_addr_i(branch_addr_i), .fetch_ready_i(fetch_ready_i),
        .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o),
        .fetch_err_o(fetch_err_o), .instr_req_o(instr_req_o),
        .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
        .instr_rdata_i(instr_rdata_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_err_i(instr_err_i), .busy_o(busy_o),
        .hwlp_jump_i(hwlp_jump_i), .hwlp_target_i(hwlp_target_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents and error map as pure functions of the word address.
    logic [31:0] err_addr;
    int          err_mod;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a == err_addr) || (err_mod != 0 && (int'(a[31:2]) % err_mod) == 0);
    endfunction

    // Reference model: in-order response queue, outstanding count, and the
    // address the next delivered word must come from.
    logic [31:0] rsp_q[$];
    int          out_m;
    logic [31:0] exp_addr;
    bit          prev_hold;
    logic [31:0] prev_addr;
    int          grants, delivered, err_seen;
    logic [31:0] last_dlv_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        rsp_q.delete();
        out_m     = 0;
        prev_hold = 1'b0;
        prev_addr = '0;
    endtask

    // One clock cycle: drive inputs on the falling edge, sample 1ns later,
    // check protocol rules and the delivered stream, update the model.
    task automatic step(input bit br, input logic [31:0] ba, input bit hj,
                        input logic [31:0] ht, input bit rdy, input bit rq,
                        input int gnt_pct, input int rv_pct);
        logic [31:0] a;
        @(negedge clk);
        req_i         = rq;
        branch_i      = br;
        branch_addr_i = ba;
        hwlp_jump_i   = hj;
        hwlp_target_i = ht;
        fetch_ready_i = rdy;
        instr_gnt_i   = (int'($urandom_range(99)) < gnt_pct);
        if (rsp_q.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
            a              = rsp_q.pop_front();
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_data(a);
            instr_err_i    = mem_err(a);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = $urandom;
            instr_err_i    = 1'b0;
        end
        #1;
        chk("busy", 32'(busy_o), 32'(instr_req_o || out_m > 0));
        if (prev_hold) begin
            chk("hold_req", 32'(instr_req_o), 32'd1);
            chk("hold_addr", instr_addr_o, prev_addr);
        end
        if (instr_req_o) begin
            chk("max_outstanding", 32'(out_m < MAXO), 32'd1);
            chk("addr_align", 32'(instr_addr_o[1:0]), 32'd0);
        end
        if (!rq && !prev_hold) chk("req_off", 32'(instr_req_o), 32'd0);
        if (br) chk("valid_in_branch", 32'(fetch_valid_o), 32'd0);
        if (fetch_valid_o && rdy) begin
            chk("dlv_data", fetch_rdata_o, mem_data(exp_addr));
            chk("dlv_err", 32'(fetch_err_o), 32'(mem_err(exp_addr)));
            delivered++;
            if (fetch_err_o) err_seen++;
            last_dlv_addr = exp_addr;
            exp_addr      = exp_addr + 32'd4;
        end
        if (br)      exp_addr = ba & ~32'h3;
        else if (hj) exp_addr = ht & ~32'h3;
        if (instr_req_o && instr_gnt_i) begin
            rsp_q.push_back(instr_addr_o);
            out_m++;
            grants++;
        end
        if (instr_rvalid_i) out_m--;
        prev_hold = instr_req_o && !instr_gnt_i;
        prev_addr = instr_addr_o;
    endtask

    typedef struct {
        bit          br;
        logic [31:0] ba;
        bit          rdy;
        int          gnt;
        int          rv;
        int          e_req;   // -1: don't care
        longint      e_addr;  // -1: don't care
        int          e_vld;   // -1: don't care
        longint      e_dat;   // address whose data must be on fetch_rdata_o, -1: don't care
    } vec_t;

    vec_t vecs[$];

    initial begin
        int g0, d0, e0;
        bit seen;
        rst_n = 1'b0; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
        fetch_ready_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
        instr_rdata_i = '0; instr_err_i = 1'b0; hwlp_jump_i = 1'b0; hwlp_target_i = '0;
        err_addr = 32'hFFFF_FFF0; err_mod = 0;
        exp_addr = '0; grants = 0; delivered = 0; err_seen = 0; last_dlv_addr = '0;
        model_reset();

        // Reset state.
        #1;
        chk("rst_req", 32'(instr_req_o), 32'd0);
        chk("rst_valid", 32'(fetch_valid_o), 32'd0);
        chk("rst_err", 32'(fetch_err_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_addr", instr_addr_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // No request before a boot address arrives.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 1, 100, 100);
            chk("boot_wait_req", 32'(instr_req_o), 32'd0);
        end

        // Boot to unaligned 0x102, streaming; held request across a branch;
        // two outstanding dropped by a branch to 0x300.
        vecs.push_back('{1, 32'h102, 1, 100, 100, 0, -1, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h100, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h104, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h108, 1, 'h100});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h10c, 1, 'h104});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h110, 1, 'h108});
        vecs.push_back('{1, 32'h100, 1, 100, 100, 0, -1, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h100, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h104, 0, -1});
        vecs.push_back('{0, 0, 1, 0, 100, 1, 'h108, 1, 'h100});
        vecs.push_back('{1, 32'h200, 1, 0, 100, 1, 'h108, 0, -1});
        vecs.push_back('{0, 0, 1, 0, 100, 1, 'h108, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h108, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h200, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h204, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h208, 1, 'h200});
        vecs.push_back('{0, 0, 1, 100, 0, 1, 'h20c, 1, 'h204});
        vecs.push_back('{0, 0, 1, 100, 0, 0, -1, 0, -1});
        vecs.push_back('{1, 32'h300, 1, 100, 0, 0, -1, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 0, -1, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h300, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h304, 0, -1});
        vecs.push_back('{0, 0, 1, 100, 100, 1, 'h308, 1, 'h300});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].br, vecs[i].ba, 0, 0, vecs[i].rdy, 1, vecs[i].gnt, vecs[i].rv);
            if (vecs[i].e_req >= 0)
                chk($sformatf("vec%0d_req", i), 32'(instr_req_o), 32'(vecs[i].e_req));
            if (vecs[i].e_addr >= 0)
                chk($sformatf("vec%0d_addr", i), instr_addr_o, 32'(vecs[i].e_addr));
            if (vecs[i].e_vld >= 0)
                chk($sformatf("vec%0d_valid", i), 32'(fetch_valid_o), 32'(vecs[i].e_vld));
            if (vecs[i].e_dat >= 0)
                chk($sformatf("vec%0d_data", i), fetch_rdata_o, mem_data(32'(vecs[i].e_dat)));
        end

        // Consumer stalled: exactly DEPTH grants, then one consume frees one slot.
        step(1, 32'h400, 0, 0, 0, 1, 100, 100);
        g0 = grants;
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 1, 100, 100);
        chk("fill_grants", 32'(grants - g0), 32'(DEPTH));
        chk("fill_req_off", 32'(instr_req_o), 32'd0);
        g0 = grants;
        step(0, 0, 0, 0, 1, 1, 100, 100);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 100, 100);
        chk("refill_grants", 32'(grants - g0), 32'd1);
        chk("refill_req_off", 32'(instr_req_o), 32'd0);

        // Bus error on one word: flagged on that word only, fetching continues.
        err_addr = 32'h508;
        step(1, 32'h500, 0, 0, 1, 1, 100, 100);
        d0 = delivered; e0 = err_seen;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 1, 100, 100);
        chk("err_words", 32'(err_seen - e0), 32'd1);
        chk("err_continue", 32'(delivered - d0 >= 5), 32'd1);
        err_addr = 32'hFFFF_FFF0;

`ifdef PREFETCH_HWLP_EN
        // Hardware-loop jump: head delivered, then stream restarts at 0x300.
        step(1, 32'h600, 0, 0, 0, 1, 100, 100);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 100, 100);
        chk("hwlp_head_valid", 32'(fetch_valid_o), 32'd1);
        d0 = delivered;
        step(0, 0, 1, 32'h302, 1, 1, 100, 100);
        chk("hwlp_head_taken", 32'(delivered - d0), 32'd1);
        chk("hwlp_head_addr", last_dlv_addr, 32'h600);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(0, 0, 0, 0, 1, 1, 100, 100);
            if (delivered > d0 + 1) seen = 1'b1;
        end
        chk("hwlp_next_seen", 32'(seen), 32'd1);
        chk("hwlp_next_addr", last_dlv_addr, 32'h300);
`endif

        // Randomized traffic with an asynchronous reset in the middle.
        err_mod = 5;
        d0 = delivered;
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("arst_req", 32'(instr_req_o), 32'd0);
                chk("arst_valid", 32'(fetch_valid_o), 32'd0);
                chk("arst_err", 32'(fetch_err_o), 32'd0);
                chk("arst_busy", 32'(busy_o), 32'd0);
                instr_rvalid_i = 1'b0; instr_gnt_i = 1'b0; branch_i = 1'b0;
                model_reset();
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    step(0, 0, 0, 0, 1, 1, 100, 100);
                    chk("arst_boot_wait", 32'(instr_req_o), 32'd0);
                end
                step(1, $urandom, 0, 0, 1, 1, 60, 50);
            end else begin
                step(int'($urandom_range(99)) < 3, $urandom, 0, 0,
                     int'($urandom_range(99)) < 70, int'($urandom_range(99)) < 90, 60, 50);
            end
        end
        chk("random_progress", 32'(delivered - d0 >= 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 The module SHALL take parameter DEPTH, default 4, as the FIFO entries, a power of two, 2..16.
REQ-002 The module SHALL take parameter MAX_OUTSTANDING, default 2, as the granted-but-unanswered bus transaction limit, 1..DEPTH.
REQ-003 The module SHALL have these ports: clk in 1 clock; rst_n in 1 async active-low reset; req_i in 1 fetch enable; branch_i in 1 redirect; branch_addr_i in 32 redirect target.
REQ-004 The module SHALL have these fetch-side ports: fetch_ready_i in 1 consumer ready; fetch_valid_o out 1 word available; fetch_rdata_o out 32 instruction word; fetch_err_o out 1 bus error flag for word.
REQ-005 The module SHALL have these memory-side ports: instr_req_o out 1; instr_gnt_i in 1; instr_addr_o out 32; instr_rdata_i in 32; instr_rvalid_i in 1; instr_err_i in 1; busy_o out 1 status.
REQ-006 The module SHALL have hwlp_jump_i in 1 and hwlp_target_i in 32 (see REQ-024).

Function
REQ-007 The module SHALL keep fetch address always word-aligned; targets SHALL be masked with bits [1:0] forced to 0.
REQ-008 The module SHALL assert instr_req_o when req_i=1, outstanding<MAX_OUTSTANDING, and fifo_count+outstanding<DEPTH.
REQ-009 Once instr_req_o=1, req and addr SHALL hold stable until instr_gnt_i=1, regardless of branch_i, req_i or fullness.
REQ-010 A grant SHALL increment outstanding and advance the fetch address by 4, wrapping modulo 2^32.
REQ-011 The instr_rvalid_i signal SHALL decrement outstanding; grant and rvalid in the same cycle SHALL leave outstanding unchanged.
REQ-012 A non-discarded response SHALL be written to the FIFO together with instr_err_i; it SHALL become visible on fetch_valid_o the next cycle (1-cycle latency, no bypass).
REQ-013 The fetch_valid_o signal SHALL equal FIFO non-empty AND NOT branch_i; the word is consumed on fetch_valid_o & fetch_ready_i.
REQ-014 The branch_i signal SHALL flush the FIFO, set discard count equal to outstanding (plus 1 if an ungranted request is held), and load fetch address with branch_addr_i.
REQ-015 Responses arriving while discard count>0 SHALL be dropped and SHALL decrement it; a response arriving in the branch cycle itself SHALL be dropped.
REQ-016 The first post-branch request to the target SHALL be issued no earlier than the cycle after branch_i.
REQ-017 A consume and a write in the same cycle SHALL leave fifo_count unchanged; a write with FIFO full SHALL never occur (guaranteed by REQ-008).
REQ-018 The instr_err_i signal SHALL not stop fetching; error words SHALL flow in order with fetch_err_o=1.
REQ-019 The busy_o signal SHALL equal instr_req_o OR outstanding>0.
REQ-020 The req_i=0 condition SHALL stop new requests only; outstanding responses still complete into the FIFO.

Reset
REQ-021 Asynchronous assertion of rst_n=0 SHALL immediately clear FIFO, outstanding, discard count, fetch address (0x0000_0000), and drive instr_req_o=0, fetch_valid_o=0, fetch_err_o=0, busy_o=0.
REQ-022 Reset mid-transaction SHALL abandon outstanding transactions; the environment SHALL not deliver their rvalid after reset.
REQ-023 On reset deassertion, the first request SHALL occur only after branch_i supplies a boot address.

Configuration
REQ-024 With PREFETCH_HWLP_EN defined, hwlp_jump_i SHALL act as a redirect to hwlp_target_i applied after the current fetch handshake: the FIFO head is delivered, then flush/redirect; branch_i in the same cycle SHALL take priority.
REQ-025 Without PREFETCH_HWLP_EN, hwlp_jump_i and hwlp_target_i SHALL be ignored and no hardware-loop logic is synthesised.

Structure
REQ-026 A shared package prefetch_pkg SHALL hold the fetch-entry typedef (32-bit data, 1-bit err), the default DEPTH and MAX_OUTSTANDING constants, and the word-alignment mask.
REQ-027 Storage SHALL be a sub-module prefetch_fifo (DEPTH-parameterised, flush input, count output); request/discard control SHALL reside in prefetch_queue.

Verification
REQ-028 Branch to 0x0000_0102, gnt immediate, rvalid +1 cycle -> instr_addr_o 0x100, 0x104, 0x108; fetch_valid_o one cycle after each rvalid.
REQ-029 DEPTH=4, fetch_ready_i=0 -> exactly 4 grants then instr_req_o=0; one consume -> one new request.
REQ-030 Two outstanding, branch to 0x200 -> both old rvalids dropped, first FIFO word is the 0x200 data, fetch_valid_o=0 in branch cycle.
REQ-031 Branch while ungranted request held at 0x108 -> addr stays 0x108 until gnt, its response dropped, next request 0x200.
REQ-032 rvalid with instr_err_i=1 -> fetch_err_o=1 on that word only, fetching continues at next address.
REQ-033 With PREFETCH_HWLP_EN, hwlp_jump_i to 0x300 while head valid and ready -> head consumed, then next delivered word from 0x300.
